// File: rtl/alu_ctrl_seq.sv
// Multi-cycle control sequencer for the 8-bit ALU datapath: fetch, decode,
// register write-back, data-memory handshake and LUT-based beq resolution.
module alu_ctrl_seq #(
   parameter int PC_W = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [8:0]      instr,
   output logic [PC_W-1:0] pc,
   output logic [2:0]      alu_cmd,
   output logic [2:0]      ra_addr,
   output logic [2:0]      rb_addr,
   input  logic            zero,
   output logic            rf_we,
   output logic [2:0]      rf_waddr,
   output logic            rf_wsel,
   output logic            dm_req,
   output logic            dm_we,
   input  logic            dm_ack,
   output logic [2:0]      lut_idx,
   input  logic [PC_W-1:0] lut_target,
   output logic            busy,
   output logic            done
);

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, DONE} state_t;

   localparam logic [2:0] OP_BEQ = 3'b011;
   localparam logic [2:0] OP_LD  = 3'b101;
   localparam logic [2:0] OP_ST  = 3'b110;
   localparam logic [8:0] HALT   = 9'b100_000_000;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic [8:0]      ir;
   logic [2:0]      op;

   assign op       = ir[8:6];
   assign ra_addr  = ir[5:3];
   assign rf_waddr = ir[5:3];
   // beq compares R[rs] against R[0]; rt is repurposed as the LUT index
   assign rb_addr  = (op == OP_BEQ) ? 3'd0 : ir[2:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= '0;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (state == FETCH) ir <= instr;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      alu_cmd   = 3'd0;
      rf_we     = 1'b0;
      rf_wsel   = 1'b0;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      lut_idx   = 3'd0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               pc_nxt    = '0;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            busy      = 1'b1;
            state_nxt = EXEC;
         end
         EXEC: begin
            busy    = 1'b1;
            alu_cmd = op;
            if (op == OP_BEQ) begin
               lut_idx   = ir[2:0];
               pc_nxt    = zero ? lut_target : pc + 1'b1;
               state_nxt = FETCH;
            end else if (op == OP_LD || op == OP_ST) begin
               state_nxt = MEM;
            end else if (ir == HALT) begin
               state_nxt = DONE;
            end else begin
               rf_we     = 1'b1;
               pc_nxt    = pc + 1'b1;
               state_nxt = FETCH;
            end
         end
         MEM: begin
            // ALU keeps producing R[rt] as the memory address while we wait
            busy    = 1'b1;
            alu_cmd = op;
            dm_req  = 1'b1;
            dm_we   = (op == OP_ST);
            if (dm_ack) begin
               rf_we     = (op == OP_LD);
               rf_wsel   = (op == OP_LD);
               pc_nxt    = pc + 1'b1;
               state_nxt = FETCH;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               pc_nxt    = '0;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
